// File: rtl/row_loader.sv
// row_loader: fetches ROWS 64-bit words from memory (row r at BASE+r) and
// streams each one, least-significant byte first, into that row's byte FIFO.
//
// Handshakes:
//  - Memory request: mem_read/mem_address are held until mem_waitrequest is
//    low. The request is accepted in that cycle. The single response is the
//    first mem_readdatavalid seen in WAIT. Valid pulses in any other state are
//    dropped.
//  - FIFO write: fifo_wren[row] is a write strobe qualified by
//    !fifo_full[row]. A byte is written, and the byte counter advances, only
//    in a cycle where the strobe is high.
`timescale 1ns/1ps
module row_loader #(
  parameter int          ROWS   = 9,
  parameter int          ADDR_W = 32,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_waitrequest,
  input  logic [63:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [ROWS-1:0]   fifo_wren,
  output logic [7:0]        fifo_wdata,
  input  logic [ROWS-1:0]   fifo_full,
  output logic [2:0]        dbg_state
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q,   row_d;
  logic [2:0]    byte_q,  byte_d;
  logic [63:0]   data_q,  data_d;

  logic          row_full;
  logic          last_row;

  assign row_full = fifo_full[row_q];
  assign last_row = (row_q == RW'(ROWS - 1));

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: sequence REQ -> WAIT -> 8x FILL per row, then DONE.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    byte_d  = byte_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          row_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!mem_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_readdatavalid) begin
          data_d  = mem_readdata;
          byte_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // A full FIFO stalls the byte counter so no byte is lost or repeated.
        if (!row_full) begin
          byte_d = byte_q + 3'd1;
          if (byte_q == 3'd7) begin
            if (last_row) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_REQ;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; only fifo_full reaches an output
  // combinationally, as the write qualifier.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    fifo_wren   = '0;
    fifo_wdata  = '0;
    case (state_q)
      S_REQ: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = ADDR_W'(BASE) + ADDR_W'(row_q);
      end
      S_WAIT: busy = 1'b1;
      S_FILL: begin
        busy       = 1'b1;
        fifo_wdata = data_q[{byte_q, 3'b000} +: 8];
        if (!row_full) fifo_wren[row_q] = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_row_loader.sv
// Testbench for row_loader: memory responder, FIFO-side monitor, and a
// byte-stream scoreboard built from the row data.
`timescale 1ns/1ps
module tb_row_loader;

  localparam int          ROWS   = 9;
  localparam int          ADDR_W = 32;
  localparam int unsigned BASE   = 32'h100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy, done, mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_waitrequest;
  logic [63:0]       mem_readdata;
  logic              mem_readdatavalid;
  logic [ROWS-1:0]   fifo_wren;
  logic [7:0]        fifo_wdata;
  logic [ROWS-1:0]   fifo_full;
  logic [2:0]        dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mem_data [ROWS];
  int          stall_rem [ROWS];
  int          req_len   [ROWS];
  int          row_cnt   [ROWS];
  int          wr_total;
  bit          spurious_en, spurious_fired;
  bit          rand_wait_en, rand_full_en;
  logic [15:0] exp_q[$];
  logic [15:0] wr_q[$];
  bit          first_seen;
  logic [ADDR_W-1:0] first_addr;
  bit          prev_read, prev_wait;
  logic [ADDR_W-1:0] prev_addr;
  int          run_len;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  row_loader #(.ROWS(ROWS), .ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .mem_read          (mem_read),
    .mem_address       (mem_address),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .fifo_wren         (fifo_wren),
    .fifo_wdata        (fifo_wdata),
    .fifo_full         (fifo_full),
    .dbg_state         (dbg_state)
  );

  // memory model: one response, one cycle after the accepting cycle
  initial begin
    bit acc;
    int acc_idx, idx;
    acc = 0; acc_idx = 0;
    mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = '0;
    forever begin
      @(posedge clk); #1;
      if (acc && rst_n) begin
        mem_readdatavalid = 1; mem_readdata = mem_data[acc_idx];
      end else if (spurious_en && mem_read && mem_address == ADDR_W'(BASE + 1)) begin
        mem_readdatavalid = 1; mem_readdata = 64'hDEADBEEF_DEADBEEF;
        spurious_en = 0; spurious_fired = 1;
      end else begin
        mem_readdatavalid = 0; mem_readdata = {$urandom, $urandom};
      end
      mem_waitrequest = 0;
      if (mem_read) begin
        idx = int'(mem_address - ADDR_W'(BASE));
        if (idx >= 0 && idx < ROWS && stall_rem[idx] > 0) begin
          mem_waitrequest = 1; stall_rem[idx]--;
        end else if (rand_wait_en) begin
          mem_waitrequest = ($urandom_range(0, 2) == 0);
        end
      end
      @(negedge clk);
      acc = rst_n && mem_read && !mem_waitrequest;
      acc_idx = int'(mem_address - ADDR_W'(BASE));
      if (acc_idx < 0 || acc_idx >= ROWS) acc = 0;
    end
  end

  // random FIFO back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_full_en)
        for (int r = 0; r < ROWS; r++) fifo_full[r] = ($urandom_range(0, 3) == 0);
    end
  end

  // monitor: collect FIFO writes, check write legality and request stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_read = 0;
    end else begin
      if (fifo_wren != '0) begin
        checks++;
        if ($countones(fifo_wren) != 1 || (fifo_wren & fifo_full) != '0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL wren_legal wren=%b full=%b busy=%b", fifo_wren, fifo_full, busy);
        end
        for (int r = 0; r < ROWS; r++)
          if (fifo_wren[r]) begin
            wr_q.push_back({8'(r), fifo_wdata});
            row_cnt[r]++;
            wr_total++;
          end
      end
      if (mem_read) begin
        if (!first_seen) begin first_seen = 1; first_addr = mem_address; end
        if (prev_read && prev_wait) begin
          checks++;
          if (mem_address !== prev_addr) begin
            failures++;
            $display("FAIL addr_stable got=%h held=%h", mem_address, prev_addr);
          end
          run_len++;
        end else begin
          run_len = 1;
        end
        if (int'(mem_address - ADDR_W'(BASE)) < ROWS)
          req_len[int'(mem_address - ADDR_W'(BASE))] = run_len;
      end
      prev_read = mem_read; prev_wait = mem_waitrequest; prev_addr = mem_address;
    end
  end

  // driver / model helpers
  task automatic clear_sb();
    wr_q.delete();
    wr_total = 0;
    first_seen = 0;
    for (int r = 0; r < ROWS; r++) begin row_cnt[r] = 0; req_len[r] = 0; end
  endtask

  task automatic set_nominal();
    for (int r = 0; r < ROWS; r++)
      mem_data[r] = 64'h0807060504030201 + 64'(r) * 64'h1010101010101010;
  endtask

  task automatic set_random();
    for (int r = 0; r < ROWS; r++) mem_data[r] = {$urandom, $urandom};
  endtask

  // reference: every row, bytes 0..7 low first, rows in ascending order
  task automatic build_exp();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 8; k++) exp_q.push_back({8'(r), mem_data[r][8*k +: 8]});
  endtask

  task automatic run_load(input int budget, input bit hold, output int edges);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1;
    if (!hold) start = 0;
    edges = 0;
    while (done !== 1'b1 && edges < budget) begin @(posedge clk); #1; edges++; end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL load_timeout done=%b after %0d cycles", done, edges);
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 0; start = 0; fifo_full = '0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy, done, mem_read} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl busy/done/read=%b exp=000", {busy, done, mem_read});
    end
    checks++;
    if (mem_address !== '0) begin
      failures++; $display("FAIL reset_addr got=%h exp=0", mem_address);
    end
    checks++;
    if (fifo_wren !== '0 || fifo_wdata !== 8'h00) begin
      failures++; $display("FAIL reset_fifo wren=%b wdata=%h exp=0", fifo_wren, fifo_wdata);
    end
    @(negedge clk); rst_n = 1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy, done, mem_read} !== 3'b000) begin
      failures++; $display("FAIL idle_hold busy/done/read=%b exp=000", {busy, done, mem_read});
    end
  endtask

  task automatic test_nominal();
    int edges, mism;
    set_nominal(); build_exp(); clear_sb();
    run_load(2000, 0, edges);
    checks++;
    if (edges != 10 * ROWS) begin
      failures++; $display("FAIL nominal_latency got=%0d exp=%0d", edges, 10 * ROWS);
    end
    checks++;
    if (wr_total != 8 * ROWS) begin
      failures++; $display("FAIL nominal_writes got=%0d exp=%0d", wr_total, 8 * ROWS);
    end
    checks++; mism = -1;
    if (wr_q.size() != exp_q.size()) mism = 0;
    else for (int i = 0; i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i] && mism < 0) mism = i;
    if (mism >= 0) begin
      failures++;
      $display("FAIL nominal_stream at %0d got=%h exp=%h size=%0d/%0d", mism,
               (mism < wr_q.size()) ? wr_q[mism] : 16'hxxxx, exp_q[mism], wr_q.size(), exp_q.size());
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL done_hold done=%b busy=%b exp=1/0", done, busy);
    end
  endtask

  task automatic test_waitrequest();
    int edges, mism;
    set_random(); build_exp(); clear_sb();
    stall_rem[4] = 3;
    run_load(2000, 0, edges);
    checks++;
    if (req_len[4] != 4 || req_len[3] != 1) begin
      failures++; $display("FAIL wait_req_len row4=%0d exp=4 row3=%0d exp=1", req_len[4], req_len[3]);
    end
    checks++;
    if (edges != 10 * ROWS + 3) begin
      failures++; $display("FAIL wait_latency got=%0d exp=%0d", edges, 10 * ROWS + 3);
    end
    checks++; mism = -1;
    if (wr_q.size() != exp_q.size()) mism = 0;
    else for (int i = 0; i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i] && mism < 0) mism = i;
    if (mism >= 0) begin
      failures++;
      $display("FAIL wait_stream at %0d got=%h exp=%h size=%0d/%0d", mism,
               (mism < wr_q.size()) ? wr_q[mism] : 16'hxxxx, exp_q[mism], wr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_fifo_full();
    int edges, mism, n;
    set_nominal(); build_exp(); clear_sb();
    fork
      run_load(2000, 0, edges);
      begin
        n = 0;
        while (row_cnt[2] < 3 && n < 2000) begin @(posedge clk); n++; end
        #1 fifo_full[2] = 1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (row_cnt[2] != 3) begin
          failures++; $display("FAIL full_stall row2 writes=%0d exp=3", row_cnt[2]);
        end
        fifo_full[2] = 0;
        @(negedge clk);
        checks++;
        if (fifo_wren !== ROWS'(1 << 2) || fifo_wdata !== 8'h24) begin
          failures++; $display("FAIL full_resume wren=%b wdata=%h exp=%b/24", fifo_wren, fifo_wdata, ROWS'(1 << 2));
        end
      end
    join
    checks++;
    if (edges != 10 * ROWS + 5) begin
      failures++; $display("FAIL full_latency got=%0d exp=%0d", edges, 10 * ROWS + 5);
    end
    checks++; mism = -1;
    if (wr_q.size() != exp_q.size()) mism = 0;
    else for (int i = 0; i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i] && mism < 0) mism = i;
    if (mism >= 0) begin
      failures++;
      $display("FAIL full_stream at %0d got=%h exp=%h size=%0d/%0d", mism,
               (mism < wr_q.size()) ? wr_q[mism] : 16'hxxxx, exp_q[mism], wr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_spurious();
    int edges, mism;
    set_random(); build_exp(); clear_sb();
    spurious_fired = 0; spurious_en = 1;
    run_load(2000, 0, edges);
    checks++;
    if (spurious_fired !== 1'b1) begin
      failures++; $display("FAIL spurious_req row1 request seen=%b exp=1", spurious_fired);
    end
    spurious_en = 0;
    checks++; mism = -1;
    if (wr_q.size() != exp_q.size()) mism = 0;
    else for (int i = 0; i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i] && mism < 0) mism = i;
    if (mism >= 0) begin
      failures++;
      $display("FAIL spurious_stream at %0d got=%h exp=%h size=%0d/%0d", mism,
               (mism < wr_q.size()) ? wr_q[mism] : 16'hxxxx, exp_q[mism], wr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int edges, mism, n, saved;
    set_nominal(); clear_sb();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    n = 0;
    while (row_cnt[5] < 2 && n < 2000) begin @(posedge clk); n++; end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy, done, mem_read} !== 3'b000 || mem_address !== '0 || fifo_wren !== '0 || fifo_wdata !== 8'h00) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b read=%b addr=%h wren=%b wdata=%h exp=all 0",
               busy, done, mem_read, mem_address, fifo_wren, fifo_wdata);
    end
    saved = wr_total;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    repeat (4) @(posedge clk); #1;
    checks++;
    if (wr_total != saved || busy !== 1'b0) begin
      failures++; $display("FAIL reset_abandon writes=%0d exp=%0d busy=%b", wr_total, saved, busy);
    end
    set_random(); build_exp(); clear_sb();
    run_load(2000, 0, edges);
    checks++;
    if (first_addr !== ADDR_W'(BASE)) begin
      failures++; $display("FAIL restart_addr got=%h exp=%h", first_addr, ADDR_W'(BASE));
    end
    checks++; mism = -1;
    if (wr_q.size() != exp_q.size()) mism = 0;
    else for (int i = 0; i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i] && mism < 0) mism = i;
    if (mism >= 0) begin
      failures++;
      $display("FAIL restart_stream at %0d got=%h exp=%h size=%0d/%0d", mism,
               (mism < wr_q.size()) ? wr_q[mism] : 16'hxxxx, exp_q[mism], wr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int edges, mism, e;
    set_random();
    run_load(2000, 1, edges);
    set_random(); build_exp(); clear_sb();
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || mem_read !== 1'b1 || mem_address !== ADDR_W'(BASE)) begin
      failures++;
      $display("FAIL b2b_restart done=%b read=%b addr=%h exp=0/1/%h", done, mem_read, mem_address, ADDR_W'(BASE));
    end
    start = 0;
    e = 0;
    // pulse start inside FILL of row 0, then across REQ/WAIT of row 1
    while (done !== 1'b1 && e < 2000) begin
      @(posedge clk); #1; e++;
      if (e == 3 || e == 10) start = 1;
      else if (e == 4 || e == 12) start = 0;
    end
    checks++;
    if (e != 10 * ROWS) begin
      failures++; $display("FAIL b2b_latency got=%0d exp=%0d", e, 10 * ROWS);
    end
    checks++; mism = -1;
    if (wr_q.size() != exp_q.size()) mism = 0;
    else for (int i = 0; i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i] && mism < 0) mism = i;
    if (mism >= 0) begin
      failures++;
      $display("FAIL b2b_stream at %0d got=%h exp=%h size=%0d/%0d", mism,
               (mism < wr_q.size()) ? wr_q[mism] : 16'hxxxx, exp_q[mism], wr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    int edges, mism;
    for (int it = 0; it < 3; it++) begin
      set_random(); build_exp(); clear_sb();
      rand_wait_en = 1; rand_full_en = 1;
      run_load(3000, 0, edges);
      rand_wait_en = 0; rand_full_en = 0;
      @(posedge clk); #1 fifo_full = '0;
      checks++; mism = -1;
      if (wr_q.size() != exp_q.size()) mism = 0;
      else for (int i = 0; i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i] && mism < 0) mism = i;
      if (mism >= 0) begin
        failures++;
        $display("FAIL random_stream it=%0d at %0d got=%h exp=%h size=%0d/%0d", it, mism,
                 (mism < wr_q.size()) ? wr_q[mism] : 16'hxxxx, exp_q[mism], wr_q.size(), exp_q.size());
      end
    end
  endtask

  // sequence and final report
  initial begin
    rst_n = 0; start = 0; fifo_full = '0;
    spurious_en = 0; spurious_fired = 0; rand_wait_en = 0; rand_full_en = 0;
    for (int r = 0; r < ROWS; r++) begin stall_rem[r] = 0; mem_data[r] = '0; end
    clear_sb();
    test_reset();
    test_nominal();
    test_waitrequest();
    test_fifo_full();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_loader.md
ROW_LOADER -- requirements
Module: row_loader

Interface
REQ-001 Parameter ROWS, default 9, number of 64-bit rows fetched per load (rows 0..7 = A matrix, row 8 = B vector).
REQ-002 Parameter ADDR_W, default 32, width of the memory word address.
REQ-003 Parameter BASE, default 0, word address of row 0; row r is read from BASE+r.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  level; sampled in IDLE or DONE to begin a load.
REQ-007 busy  output  1  high in REQ, WAIT and FILL.
REQ-008 done  output  1  high while in DONE.
REQ-009 mem_read  output  1  memory read request.
REQ-010 mem_address  output  ADDR_W  memory word address.
REQ-011 mem_waitrequest  input  1  memory stall; request accepted in the cycle it is low.
REQ-012 mem_readdata  input  64  read data.
REQ-013 mem_readdatavalid  input  1  qualifies mem_readdata.
REQ-014 fifo_wren  output  ROWS  one-hot write enable; bit r drives the FIFO for row r.
REQ-015 fifo_wdata  output  8  byte shared by all row FIFOs.
REQ-016 fifo_full  input  ROWS  full flag of each row FIFO.

Function
REQ-017 FSM states IDLE, REQ, WAIT, FILL, DONE; registers row_idx (0..ROWS-1), byte_cnt (0..7) and data_q (64 bits).
REQ-018 IDLE: start=1 -> row_idx=0, go to REQ; otherwise stay.
REQ-019 REQ: mem_read=1, mem_address=BASE+row_idx; mem_waitrequest=0 -> WAIT; otherwise hold mem_read and mem_address stable.
REQ-020 WAIT: mem_read=0; mem_readdatavalid=1 -> data_q=mem_readdata, byte_cnt=0, go to FILL.
REQ-021 mem_readdatavalid outside WAIT is ignored; data_q does not change.
REQ-022 FILL: when fifo_full[row_idx]=0 -> fifo_wren[row_idx]=1, fifo_wdata=data_q[8*byte_cnt+7 -: 8] (byte 0 = bits 7:0 first), byte_cnt increments.
REQ-023 FILL with fifo_full[row_idx]=1 -> fifo_wren=0, byte_cnt holds (stall, no byte lost or repeated).
REQ-024 After the write with byte_cnt=7: row_idx<ROWS-1 -> row_idx+1, go to REQ; row_idx=ROWS-1 -> go to DONE.
REQ-025 At most one fifo_wren bit is high in any cycle; fifo_wren=0 outside FILL.
REQ-026 DONE: done=1; start=1 -> row_idx=0, go to REQ (done drops next cycle); otherwise stay.
REQ-027 start in REQ, WAIT or FILL is ignored.
REQ-028 Outputs are decoded from registered state only (no combinational path from mem_* inputs to outputs); fifo_full gates fifo_wren combinationally.
REQ-029 Unstalled timing (waitrequest=0, readdatavalid one cycle after acceptance, no full): 10 cycles per row; start sampled at edge 0 -> done high from cycle 1+10*ROWS (91 for ROWS=9).

Reset
REQ-030 rst_n low: state=IDLE, row_idx=0, byte_cnt=0, data_q=0, immediately and regardless of clk.
REQ-031 Reset values: busy=0, done=0, mem_read=0, mem_address=0, fifo_wren=0, fifo_wdata=0.
REQ-032 Reset mid-load abandons the load; no further FIFO writes; after release a new start restarts from row 0.

Verification
REQ-033 Nominal: memory returns 64'h0807060504030201+r*64'h1010101010101010 for row r, no stalls -> FIFO r receives bytes 01+10r..08+10r in order; done at cycle 91; exactly 72 writes total.
REQ-034 waitrequest high for 3 cycles on row 4 -> mem_read and mem_address=BASE+4 stable for 4 cycles; data unchanged; done delayed by 3 cycles.
REQ-035 fifo_full[2] high for 5 cycles after the 3rd byte of row 2 -> no writes during the stall; 4th byte 0x24 written the cycle full drops; no byte dropped or duplicated.
REQ-036 Spurious readdatavalid with 64'hDEADBEEF_DEADBEEF during REQ of row 1 -> ignored; FIFO 1 gets the real row 1 data.
REQ-037 rst_n low during FILL of row 5 -> all outputs 0 within the same cycle; start after release -> row 0 re-read from BASE.
REQ-038 start held high through DONE -> second load begins the cycle after DONE; start pulsed during FILL -> no effect.
